// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one AXI-style memory/display slave between two requesters.
// Optional watchdog abort of stalled transactions is compiled in with ARB_TIMEOUT_EN.
module axi_mem_arbiter #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*ADDR_W-1:0]   req_wdata,
  output logic [1:0]            req_ack,
  output logic [1:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  m_arvalid,
  output logic [ADDR_W-1:0]     m_araddr,
  input  logic                  s_arready,
  output logic                  m_rready,
  input  logic                  s_rvalid,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  m_awvalid,
  input  logic                  s_awready,
  output logic                  m_wvalid,
  output logic [ADDR_W-1:0]     m_wdata,
  input  logic                  s_wready
);

  localparam int unsigned WDOG_W = 8;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT >= (1 << WDOG_W)) begin : g_bad_timeout
    $error("TIMEOUT does not fit the watchdog counter");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_RD_CAP  = 3'd3,
    S_WR_ADDR = 3'd4,
    S_WR_DATA = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_wdata;

  logic                w_win;
  logic                w_win_write;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [ADDR_W-1:0]   w_win_wdata;
  logic [ADDR_W-1:0]   w_sel_addr;

  logic [1:0]          w_ack_nxt;
  logic [1:0]          w_resp_valid_nxt;
  logic [DATA_W-1:0]   w_resp_data_nxt;
  logic                w_busy_nxt;
  logic                w_arvalid_nxt;
  logic [ADDR_W-1:0]   w_araddr_nxt;
  logic                w_rready_nxt;
  logic                w_awvalid_nxt;
  logic                w_wvalid_nxt;
  logic [ADDR_W-1:0]   w_wdata_nxt;

  // Lone requester wins; on contention the one not served last time wins.
  assign w_win       = (req_valid == 2'b10) ? 1'b1 :
                       (req_valid == 2'b11) ? ~r_last_grant : 1'b0;
  assign w_win_write = req_write[w_win];
  assign w_win_addr  = w_win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign w_win_wdata = w_win ? req_wdata[2*ADDR_W-1:ADDR_W] : req_wdata[ADDR_W-1:0];

`ifdef ARB_TIMEOUT_EN
  logic [WDOG_W-1:0]   r_wdog;
  logic                w_wait_state;
  logic                w_timeout;

  assign w_wait_state = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                        (r_state == S_WR_ADDR) || (r_state == S_WR_DATA);
  assign w_timeout    = w_wait_state && (r_wdog == WDOG_W'(TIMEOUT));

  // Watchdog restarts whenever the FSM moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_wdog <= '0;
    else if (w_state_nxt != r_state) r_wdog <= '0;
    else                           r_wdog <= r_wdog + WDOG_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) resp_err <= 1'b0;
    else       resp_err <= (w_state_nxt == S_RESP) && w_timeout;
  end
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (|req_valid) w_state_nxt = w_win_write ? S_WR_ADDR : S_RD_ADDR;
      S_RD_ADDR: if (s_arready)  w_state_nxt = S_RD_DATA;
      S_RD_DATA: if (s_rvalid)   w_state_nxt = S_RD_CAP;
      S_RD_CAP:                  w_state_nxt = S_RESP;
      S_WR_ADDR: if (s_awready)  w_state_nxt = S_WR_DATA;
      S_WR_DATA: if (s_wready)   w_state_nxt = S_RESP;
      S_RESP:                    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    if (w_timeout) w_state_nxt = S_RESP;
`endif
  end

  // Outputs are decoded from the next state so that they are registered yet
  // line up with the state they belong to.
  assign w_sel_addr = (r_state == S_IDLE) ? w_win_addr : r_addr;

  always_comb begin
    w_ack_nxt        = 2'b00;
    w_resp_valid_nxt = 2'b00;
    w_resp_data_nxt  = '0;
    w_arvalid_nxt    = 1'b0;
    w_araddr_nxt     = '0;
    w_rready_nxt     = 1'b0;
    w_awvalid_nxt    = 1'b0;
    w_wvalid_nxt     = 1'b0;
    w_wdata_nxt      = '0;
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    if ((r_state == S_IDLE) && (|req_valid)) w_ack_nxt[w_win] = 1'b1;
    if ((w_state_nxt == S_RD_ADDR) || (w_state_nxt == S_RD_DATA)) w_arvalid_nxt = 1'b1;
    if (w_state_nxt == S_RD_DATA) w_rready_nxt = 1'b1;
    if ((w_state_nxt == S_WR_ADDR) || (w_state_nxt == S_WR_DATA)) w_awvalid_nxt = 1'b1;
    if (w_arvalid_nxt || w_awvalid_nxt) w_araddr_nxt = w_sel_addr;
    if (w_state_nxt == S_WR_DATA) begin
      w_wvalid_nxt = 1'b1;
      w_wdata_nxt  = r_wdata;
    end
    if (w_state_nxt == S_RESP) w_resp_valid_nxt[r_owner] = 1'b1;
    // Slave presents registered read data in the cycle after the R handshake.
    if ((r_state == S_RD_CAP) && (w_state_nxt == S_RESP)) w_resp_data_nxt = s_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ack    <= 2'b00;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      busy       <= 1'b0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_rready   <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_wdata    <= '0;
    end else begin
      req_ack    <= w_ack_nxt;
      resp_valid <= w_resp_valid_nxt;
      resp_data  <= w_resp_data_nxt;
      busy       <= w_busy_nxt;
      m_arvalid  <= w_arvalid_nxt;
      m_araddr   <= w_araddr_nxt;
      m_rready   <= w_rready_nxt;
      m_awvalid  <= w_awvalid_nxt;
      m_wvalid   <= w_wvalid_nxt;
      m_wdata    <= w_wdata_nxt;
    end
  end

  // Request latch on grant; round-robin pointer advances on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      if ((r_state == S_IDLE) && (|req_valid)) begin
        r_owner <= w_win;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
      if (r_state == S_RESP) r_last_grant <= r_owner;
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Randomized bench for axi_mem_arbiter: slave BFM plus a transaction-level reference
// model (round-robin rule and a shadow memory). Honours ARB_TIMEOUT_EN like the RTL.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0, req_write = '0;
  logic [7:0]  req_addr = '0, req_wdata = '0;
  logic [1:0]  req_ack, resp_valid;
  logic [7:0]  resp_data;
  logic        resp_err, busy;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid;
  logic [3:0]  m_araddr, m_wdata;
  logic        s_arready = 1'b0, s_rvalid = 1'b0, s_awready = 1'b0, s_wready = 1'b0;
  logic [7:0]  s_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .s_arready(s_arready),
    .m_rready(m_rready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .m_awvalid(m_awvalid), .s_awready(s_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .s_wready(s_wready)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({req_ack, resp_valid, resp_data, resp_err, busy, m_arvalid, m_araddr,
                m_rready, m_awvalid, m_wvalid, m_wdata});
  endfunction

  // Slave BFM: 16x8 memory, random ready delays, no awready for address 0.
  logic [7:0] bfm_mem [16];
  int         bfm_ph = 0;
  bit         bfm_rd_pend = 0;
  bit         bfm_stall = 0;
  logic [3:0] bfm_addr = '0;

  always @(negedge clk) begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    if (reset) begin
      bfm_ph      = 0;
      bfm_rd_pend = 0;
      s_rdata     = 8'($urandom);
    end else begin
      if (bfm_rd_pend) begin
        s_rdata     = bfm_mem[bfm_addr];
        bfm_rd_pend = 0;
      end else begin
        s_rdata = 8'($urandom);
      end
      case (bfm_ph)
        0: begin
          if (m_arvalid && !m_rready && ($urandom_range(0, 2) != 0)) begin
            s_arready = 1'b1; bfm_ph = 1; bfm_addr = m_araddr;
          end else if (m_awvalid && !m_wvalid && (m_araddr != 4'h0) &&
                       ($urandom_range(0, 2) != 0)) begin
            s_awready = 1'b1; bfm_ph = 2; bfm_addr = m_araddr;
          end
        end
        1: if (m_rready && !bfm_stall && ($urandom_range(0, 2) != 0)) begin
          s_rvalid = 1'b1; bfm_rd_pend = 1; bfm_ph = 0;
        end
        2: if (m_wvalid && ($urandom_range(0, 2) != 0)) begin
          s_wready = 1'b1; bfm_mem[bfm_addr] = {4'h0, m_wdata}; bfm_ph = 0;
        end
        default: bfm_ph = 0;
      endcase
    end
  end

  // Reference model: who was served last and what memory should hold.
  logic       m_last = 1'b1;
  logic [7:0] ref_mem [16];

  task automatic do_reset();
    @(negedge clk);
    req_valid = 2'b00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("reset_outputs", outs(), 32'h0);
    reset = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic wait_ack(input logic [1:0] exp_ack);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ack != 2'b00) got = 1;
    end
    chk_eq("req_ack", 32'(req_ack), 32'(exp_ack));
    req_valid = 2'b00;
  endtask

  task automatic run_txn(input logic [1:0] vm, input logic [1:0] wr,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] wd0, input logic [3:0] wd1, input bit stray);
    logic       win, w;
    logic [3:0] a, wd;
    logic [1:0] exp_mask;
    logic [7:0] exp_data;
    bit         got, extra;
    win      = (vm == 2'b11) ? ~m_last : vm[1];
    a        = win ? a1 : a0;
    wd       = win ? wd1 : wd0;
    w        = wr[win];
    exp_mask = win ? 2'b10 : 2'b01;
    exp_data = w ? 8'h00 : ref_mem[a];
    @(negedge clk);
    req_valid = vm; req_write = wr; req_addr = {a1, a0}; req_wdata = {wd1, wd0};
    wait_ack(exp_mask);
    got = 0; extra = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (req_ack != 2'b00) extra = 1;
      // A short request from the idle side while busy must be lost.
      if (n == 0 && stray) req_valid = ~vm;
      else                 req_valid = 2'b00;
      if (resp_valid != 2'b00) got = 1;
    end
    req_valid = 2'b00;
    chk_eq("resp_valid", 32'(resp_valid), 32'(exp_mask));
    chk_eq("resp_data", 32'(resp_data), 32'(exp_data));
    chk_eq("resp_err", 32'(resp_err), 32'h0);
    chk_eq("no_extra_ack", 32'(extra), 32'h0);
    @(negedge clk);
    chk_eq("busy_after_resp", 32'(busy), 32'h0);
    m_last = win;
    if (w) ref_mem[a] = {4'h0, wd};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit         seen, got;
    logic [1:0] vm, wr;
    logic [3:0] a0, a1;
    for (int i = 0; i < 16; i++) begin
      bfm_mem[i] = 8'(i * 4 + 1);
      ref_mem[i] = 8'(i * 4 + 1);
    end
    #1 reset = 1'b1;
    do_reset();

    // Directed: read, write, read-back.
    run_txn(2'b01, 2'b00, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
    chk_eq("ref_addr3", 32'(ref_mem[3]), 32'h0D);
    run_txn(2'b01, 2'b01, 4'd5, 4'd2, 4'd9, 4'd4, 1'b0);
    run_txn(2'b01, 2'b00, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);

    // Contention straight after reset: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 2'($urandom) & 2'b00, 4'($urandom), 4'($urandom), 4'd0, 4'd0, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      vm = 2'($urandom_range(1, 3));
      wr = 2'($urandom);
      a0 = 4'($urandom);
      a1 = 4'($urandom);
      if (wr[0] && a0 == 4'h0) a0 = 4'h1;
      if (wr[1] && a1 == 4'h0) a1 = 4'h2;
      run_txn(vm, wr, a0, a1, 4'($urandom), 4'($urandom),
              (vm != 2'b11) && ($urandom_range(0, 1) == 1));
    end

    // Reset while waiting in RD_DATA aborts silently.
    bfm_stall = 1;
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h07;
    wait_ack(2'b01);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (m_rready) got = 1;
    end
    chk_eq("rd_data_reached", 32'(got), 32'h1);
    reset = 1'b1;
    #1 chk_eq("reset_async", outs(), 32'h0);
    @(negedge clk);
    chk_eq("reset_next_cycle", outs(), 32'h0);
    reset = 1'b0;
    bfm_stall = 0;
    m_last = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen = 1;
    end
    chk_eq("reset_no_resp", 32'(seen), 32'h0);
    run_txn(2'b01, 2'b00, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0);

    // Write to address 0: never accepted by the slave.
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h00; req_wdata = 8'h05;
    wait_ack(2'b01);
`ifdef ARB_TIMEOUT_EN
    got = 0;
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) got = 1;
    end
    chk_eq("to_resp_valid", 32'(resp_valid), 32'h1);
    chk_eq("to_resp_err", 32'(resp_err), 32'h1);
    chk_eq("to_resp_data", 32'(resp_data), 32'h0);
    chk_eq("to_awvalid_drop", 32'(m_awvalid), 32'h0);
    @(negedge clk);
    chk_eq("to_busy", 32'(busy), 32'h0);
    m_last = 1'b0;
`else
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen = 1;
    end
    chk_eq("stall_no_resp", 32'(seen), 32'h0);
    chk_eq("stall_busy", 32'(busy), 32'h1);
    chk_eq("stall_awvalid", 32'(m_awvalid), 32'h1);
    chk_eq("stall_wvalid", 32'(m_wvalid), 32'h0);
    do_reset();
`endif
    chk_eq("ref_addr0", 32'(bfm_mem[0]), 32'(ref_mem[0]));
    run_txn(2'b11, 2'b00, 4'd5, 4'd3, 4'd0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
